// File: rtl/jtbubl_snd_if_if.sv
// Main-CPU bus window shared between the CPU (master) and the sound port (slave).
interface jtbubl_snd_if_if;
    logic       cs;
    logic [1:0] addr;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq_n;

    modport master (output cs, addr, rd_n, wr_n, din, input dout, irq_n);
    modport slave  (input cs, addr, rd_n, wr_n, din, output dout, irq_n);
endinterface

// File: rtl/jtbubl_snd_if.sv
// Main-CPU side of the Bubble Bobble sound link: command/reply latches,
// reply IRQ and the sound subsystem reset sequencer.
module jtbubl_snd_if #(
    parameter int RST_HOLD = 16,
    parameter int CW       = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    jtbubl_snd_if_if.slave       bus,
    output logic [7:0]           snd_latch,
    output logic                 snd_stb,
    input  logic                 snd_flag,
    input  logic [7:0]           main_latch,
    input  logic                 main_stb,
    output logic                 main_flag,
    output logic                 snd_rstn
);
    typedef enum logic [1:0] {HOLD, RUN, SOFT} state_t;

    localparam logic [CW-1:0] HOLD_CNT = CW'(RST_HOLD);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          wr_l, rd_l, stb_l;
    logic          wr_e, rd_e, stb_rise;
    logic [7:0]    rply;
    logic          ovr, irq_en, soft_rst, irq_q;
    logic [7:0]    dout_c;

    assign wr_e     = bus.cs & ~bus.wr_n & wr_l;
    assign rd_e     = bus.cs & ~bus.rd_n & rd_l;
    assign stb_rise = main_stb & ~stb_l;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_l  <= 1'b1;
            rd_l  <= 1'b1;
            stb_l <= 1'b0;
        end else begin
            wr_l  <= bus.wr_n;
            rd_l  <= bus.rd_n;
            stb_l <= main_stb;
        end
    end

    // While the sound side is in reset its flags are forced clear and strobes are suppressed
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            snd_latch <= 8'h00;
            snd_stb   <= 1'b0;
            rply      <= 8'h00;
            main_flag <= 1'b0;
            ovr       <= 1'b0;
            irq_en    <= 1'b0;
            soft_rst  <= 1'b0;
            irq_q     <= 1'b1;
        end else begin
            snd_stb <= 1'b0;
            irq_q   <= ~(irq_en & main_flag);
            if (wr_e) begin
                case (bus.addr)
                    2'd0: begin
                        snd_latch <= bus.din;
                        if (snd_rstn) begin
                            snd_stb <= 1'b1;
                            if (!snd_flag) ovr <= 1'b1;
                        end
                    end
                    2'd1:    irq_en   <= bus.din[0];
                    2'd3:    soft_rst <= bus.din[0];
                    default: ;
                endcase
            end
            if (rd_e && bus.addr == 2'd1) ovr <= 1'b0;
            if (snd_rstn && stb_rise) begin
                rply      <= main_latch;
                main_flag <= 1'b1;
            end else if (rd_e && bus.addr == 2'd0) begin
                main_flag <= 1'b0;
            end
            if (!snd_rstn) begin
                main_flag <= 1'b0;
                ovr       <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= HOLD;
            cnt      <= HOLD_CNT;
            snd_rstn <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (soft_rst) begin
                        state    <= SOFT;
                        snd_rstn <= 1'b0;
                    end else if (cnt == '0) begin
                        state    <= RUN;
                        snd_rstn <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RUN: begin
                    if (soft_rst) begin
                        state    <= SOFT;
                        snd_rstn <= 1'b0;
                    end
                end
                SOFT: begin
                    snd_rstn <= 1'b0;
                    if (!soft_rst) begin
                        cnt   <= HOLD_CNT;
                        state <= HOLD;
                    end
                end
                default: begin
                    state    <= HOLD;
                    snd_rstn <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        dout_c = 8'hFF;
        if (bus.cs && !bus.rd_n) begin
            case (bus.addr)
                2'd0:    dout_c = rply;
                2'd1:    dout_c = {4'hF, irq_en, ovr, ~snd_flag, main_flag};
                2'd2:    dout_c = 8'hFF;
                default: dout_c = {7'h7F, soft_rst};
            endcase
        end
    end

    assign bus.dout  = dout_c;
    assign bus.irq_n = irq_q;
endmodule

// File: tb/tb_jtbubl_snd_if.sv
// Scoreboard bench for jtbubl_snd_if: stimulus queues cycle-stamped
// expectations, a negedge monitor compares them against the DUT.
module tb_jtbubl_snd_if;
    localparam int H = 16;

    localparam int S_DOUT  = 0;
    localparam int S_IRQN  = 1;
    localparam int S_LATCH = 2;
    localparam int S_STB   = 3;
    localparam int S_MFLAG = 4;
    localparam int S_SRSTN = 5;

    typedef struct {
        string      name;
        int         sel;
        logic [7:0] exp;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] snd_latch;
    logic       snd_stb;
    logic       snd_flag = 1'b1;
    logic [7:0] main_latch = 8'h00;
    logic       main_stb = 1'b0;
    logic       main_flag;
    logic       snd_rstn;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    jtbubl_snd_if_if bus ();

    jtbubl_snd_if #(.RST_HOLD(H), .CW(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .snd_latch  (snd_latch),
        .snd_stb    (snd_stb),
        .snd_flag   (snd_flag),
        .main_latch (main_latch),
        .main_stb   (main_stb),
        .main_flag  (main_flag),
        .snd_rstn   (snd_rstn)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] actual(input int sel);
        case (sel)
            S_DOUT:  return bus.dout;
            S_IRQN:  return {7'd0, bus.irq_n};
            S_LATCH: return snd_latch;
            S_STB:   return {7'd0, snd_stb};
            S_MFLAG: return {7'd0, main_flag};
            default: return {7'd0, snd_rstn};
        endcase
    endfunction

    // Monitor: retire every expectation whose cycle has arrived
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                logic [7:0] act;
                act = actual(sb[i].sel);
                checks++;
                if (act !== sb[i].exp) begin
                    failures++;
                    $display("[TB] FAIL %s: got %02h expected %02h (cycle %0d)",
                             sb[i].name, act, sb[i].exp, cyc);
                end
                sb.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input int sel,
                                input logic [7:0] exp, input int offset);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        e.due  = cyc + offset;
        sb.push_back(e);
    endtask

    task automatic apply_stimulus(input bit is_wr, input logic [1:0] a,
                                  input logic [7:0] d, input int len);
        bus.cs   = 1'b1;
        bus.addr = a;
        bus.din  = d;
        if (is_wr) bus.wr_n = 1'b0;
        else       bus.rd_n = 1'b0;
        repeat (len) tick();
        bus.wr_n = 1'b1;
        bus.rd_n = 1'b1;
        bus.cs   = 1'b0;
    endtask

    initial begin
        bus.cs   = 1'b0;
        bus.addr = 2'd0;
        bus.din  = 8'h00;
        bus.rd_n = 1'b1;
        bus.wr_n = 1'b1;

        $display("[TB] power-up");
        tick();
        tick();
        check_output("rst_latch", S_LATCH, 8'h00, 0);
        check_output("rst_stb",   S_STB,   8'h00, 0);
        check_output("rst_mflag", S_MFLAG, 8'h00, 0);
        check_output("rst_srstn", S_SRSTN, 8'h00, 0);
        check_output("rst_irqn",  S_IRQN,  8'h01, 0);
        check_output("rst_dout",  S_DOUT,  8'hFF, 0);
        tick();
        rstn = 1'b1;
        check_output("pwr_srstn_low",  S_SRSTN, 8'h00, H);
        check_output("pwr_srstn_high", S_SRSTN, 8'h01, H + 1);
        check_output("pwr_irqn",       S_IRQN,  8'h01, H + 1);
        repeat (H + 3) tick();

        $display("[TB] command write");
        check_output("cmd_latch", S_LATCH, 8'h5A, 1);
        check_output("cmd_stb1",  S_STB,   8'h01, 1);
        for (int k = 2; k <= 5; k++) check_output("cmd_stb0", S_STB, 8'h00, k);
        apply_stimulus(1'b1, 2'd0, 8'h5A, 4);
        tick();
        check_output("cmd_status", S_DOUT, 8'hF0, 0);
        apply_stimulus(1'b0, 2'd1, 8'h00, 1);
        tick();
        check_output("addr2_read", S_DOUT, 8'hFF, 0);
        apply_stimulus(1'b0, 2'd2, 8'h00, 1);
        check_output("idle_dout", S_DOUT, 8'hFF, 0);

        $display("[TB] overrun");
        tick();
        snd_flag = 1'b0;
        check_output("ovr_latch", S_LATCH, 8'h11, 1);
        check_output("ovr_stb",   S_STB,   8'h01, 1);
        apply_stimulus(1'b1, 2'd0, 8'h11, 1);
        tick();
        check_output("ovr_status1", S_DOUT, 8'hF6, 0);
        apply_stimulus(1'b0, 2'd1, 8'h00, 1);
        tick();
        check_output("ovr_status2", S_DOUT, 8'hF2, 0);
        apply_stimulus(1'b0, 2'd1, 8'h00, 1);
        snd_flag = 1'b1;

        $display("[TB] reply and irq");
        tick();
        apply_stimulus(1'b1, 2'd1, 8'h01, 1);
        main_latch = 8'hC3;
        tick();
        main_stb = 1'b1;
        check_output("rply_mflag0", S_MFLAG, 8'h00, 0);
        check_output("rply_mflag1", S_MFLAG, 8'h01, 1);
        check_output("rply_irqn1",  S_IRQN,  8'h01, 1);
        check_output("rply_irqn0",  S_IRQN,  8'h00, 2);
        repeat (3) tick();
        main_stb = 1'b0;
        tick();
        check_output("rply_dout",    S_DOUT,  8'hC3, 0);
        check_output("rply_clr",     S_MFLAG, 8'h00, 1);
        check_output("rply_irq_off", S_IRQN,  8'h01, 2);
        apply_stimulus(1'b0, 2'd0, 8'h00, 1);
        tick();
        main_latch = 8'hA5;
        main_stb   = 1'b1;
        check_output("race_dout",   S_DOUT,  8'hC3, 0);
        check_output("race_mflag1", S_MFLAG, 8'h01, 1);
        check_output("race_mflag2", S_MFLAG, 8'h01, 2);
        apply_stimulus(1'b0, 2'd0, 8'h00, 1);
        tick();
        main_stb = 1'b0;
        tick();
        check_output("race_dout2", S_DOUT,  8'hA5, 0);
        check_output("race_clr",   S_MFLAG, 8'h00, 1);
        apply_stimulus(1'b0, 2'd0, 8'h00, 1);

        $display("[TB] soft reset");
        tick();
        check_output("soft_srstn_pre", S_SRSTN, 8'h01, 1);
        check_output("soft_srstn_on",  S_SRSTN, 8'h00, 2);
        apply_stimulus(1'b1, 2'd3, 8'h01, 1);
        tick();
        check_output("soft_reg", S_DOUT, 8'hFF, 0);
        apply_stimulus(1'b0, 2'd3, 8'h00, 1);
        tick();
        snd_flag = 1'b0;
        check_output("soft_latch", S_LATCH, 8'h33, 1);
        check_output("soft_stb1",  S_STB,   8'h00, 1);
        check_output("soft_stb2",  S_STB,   8'h00, 2);
        apply_stimulus(1'b1, 2'd0, 8'h33, 1);
        snd_flag   = 1'b1;
        main_latch = 8'h77;
        main_stb   = 1'b1;
        for (int k = 1; k <= 3; k++) check_output("soft_mflag", S_MFLAG, 8'h00, k);
        repeat (2) tick();
        main_stb = 1'b0;
        tick();
        check_output("soft_rply_kept", S_DOUT, 8'hA5, 0);
        apply_stimulus(1'b0, 2'd0, 8'h00, 1);
        tick();
        check_output("soft_status", S_DOUT, 8'hF8, 0);
        apply_stimulus(1'b0, 2'd1, 8'h00, 1);
        tick();
        check_output("soft_rel_low",  S_SRSTN, 8'h00, H + 1);
        check_output("soft_rel_high", S_SRSTN, 8'h01, H + 3);
        apply_stimulus(1'b1, 2'd3, 8'h00, 1);
        repeat (H + 5) tick();

        $display("[TB] async reset mid-access");
        bus.cs   = 1'b1;
        bus.addr = 2'd0;
        bus.din  = 8'h99;
        bus.wr_n = 1'b0;
        tick();
        rstn = 1'b0;
        check_output("arst_latch", S_LATCH, 8'h00, 0);
        check_output("arst_stb",   S_STB,   8'h00, 0);
        check_output("arst_srstn", S_SRSTN, 8'h00, 0);
        check_output("arst_irqn",  S_IRQN,  8'h01, 0);
        tick();
        rstn = 1'b1;
        for (int k = 0; k <= 4; k++) check_output("arst_no_stb", S_STB, 8'h00, k);
        check_output("arst_srstn_hold", S_SRSTN, 8'h00, 2);
        repeat (3) tick();
        bus.wr_n = 1'b1;
        bus.cs   = 1'b0;
        tick();
        check_output("arst_status", S_DOUT, 8'hF0, 0);
        apply_stimulus(1'b0, 2'd1, 8'h00, 1);

        for (int i = 0; i < 200 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain: got %0d pending expected 0 pending", sb.size());
        end
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
